// File: rtl/spi_target.sv
// ---------------------------------------------------------------------------
// spi_target
//   SPI target (peripheral) endpoint. MSB-first 8-bit frames, SCK idle low,
//   CSX active low. SDI is sampled on SCK rise, SDO shifts on SCK fall. All
//   pins are oversampled and synchronized into clk.
//
// Parameters
//   SYNC_STAGES  synchronizer depth for CSX/SCK/SDI (2..3)
//   IDLE_BYTE    byte shifted out when no tx byte is queued
//
// Ports
//   clk, rst_n          target clock, async active-low reset
//   CSX, SCK, SDI       SPI pins from the initiator
//   SDO, SDO_OE         SPI data out and its output enable
//   tx_data/valid/ready tx byte handshake (one-byte buffer)
//   rx_data/valid/ack   rx byte handshake (rx_valid sticky until ack)
//   selected            synchronized, inverted CSX
//   rx_overrun          only with SPI_TARGET_OVERRUN_EN defined
//
// Optional feature macro: SPI_TARGET_OVERRUN_EN
// ---------------------------------------------------------------------------
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       CSX,
    input  logic       SCK,
    input  logic       SDI,
    output logic       SDO,
    output logic       SDO_OE,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       selected
`ifdef SPI_TARGET_OVERRUN_EN
    ,
    output logic       rx_overrun
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] csx_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] sync_ok;
    logic                   csx_s;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   csx_q;
    logic                   sck_q;
    logic                   rise_p;
    logic                   fall_p;
    logic                   sdi_p;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_shift;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_buf;
    logic                   tx_full;

    assign csx_s    = csx_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];

    assign selected = ~csx_s;
    assign tx_ready = ~tx_full;
    assign SDO_OE   = (state == ACTIVE);
    assign SDO      = SDO_OE & tx_shift[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csx_sync   <= '1;
            sck_sync   <= '0;
            sdi_sync   <= '0;
            sync_ok    <= '0;
            csx_q      <= 1'b1;
            sck_q      <= 1'b0;
            rise_p     <= 1'b0;
            fall_p     <= 1'b0;
            sdi_p      <= 1'b0;
            armed      <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_shift   <= IDLE_BYTE;
            rx_shift   <= '0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
            rx_overrun <= 1'b0;
`endif
        end else begin
            csx_sync <= {csx_sync[SYNC_STAGES-2:0], CSX};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            // sync_ok marks when csx_s holds a real pin sample rather than
            // the reset preset, so a CSX low at reset release is not
            // mistaken for a fresh select.
            sync_ok  <= {sync_ok[SYNC_STAGES-2:0], 1'b1};

            csx_q  <= csx_s;
            sck_q  <= sck_s;
            // Edge pulses and SDI are registered together so the data bit
            // stays aligned with its rise pulse.
            rise_p <= sck_s & ~sck_q;
            fall_p <= ~sck_s & sck_q;
            sdi_p  <= sdi_s;

            if (sync_ok[SYNC_STAGES-1] && csx_s) begin
                armed <= 1'b1;
            end

            // Writes need an empty buffer, pulls need a full one, so the two
            // tx_full updates below never land in the same clk.
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (rx_ack) begin
                rx_valid <= 1'b0;
            end
`ifdef SPI_TARGET_OVERRUN_EN
            if (rx_ack) begin
                rx_overrun <= 1'b0;
            end
`endif

            case (state)
                IDLE: begin
                    if (armed && csx_q && !csx_s) begin
                        state   <= ACTIVE;
                        bit_cnt <= '0;
                        if (tx_full) begin
                            tx_shift <= tx_buf;
                            tx_full  <= 1'b0;
                        end else begin
                            tx_shift <= IDLE_BYTE;
                        end
                    end
                end
                ACTIVE: begin
                    if (csx_s) begin
                        // Deselect drops any partial byte.
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else begin
                        if (rise_p) begin
                            rx_shift <= {rx_shift[6:0], sdi_p};
                            if (bit_cnt == 3'd7) begin
                                bit_cnt  <= '0;
                                rx_data  <= {rx_shift[6:0], sdi_p};
                                rx_valid <= 1'b1;
`ifdef SPI_TARGET_OVERRUN_EN
                                if (rx_valid && !rx_ack) begin
                                    rx_overrun <= 1'b1;
                                end
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        if (fall_p) begin
                            if (bit_cnt != 3'd0) begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end else if (tx_full) begin
                                tx_shift <= tx_buf;
                                tx_full  <= 1'b0;
                            end else begin
                                tx_shift <= IDLE_BYTE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// ---------------------------------------------------------------------------
// tb_spi_target
//   Directed bench for spi_target: acts as the SPI initiator (mode 0,
//   12-clk SCK period) and as the local host. Build with
//   SPI_TARGET_OVERRUN_EN defined to cover the overrun flag.
// ---------------------------------------------------------------------------
module tb_spi_target;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       clk;
    logic       rst_n;
    logic       CSX;
    logic       SCK;
    logic       SDI;
    logic       SDO;
    logic       SDO_OE;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       selected;
`ifdef SPI_TARGET_OVERRUN_EN
    logic       rx_overrun;
`endif

    int checks;
    int fails;

    spi_target #(
        .SYNC_STAGES(SYNC),
        .IDLE_BYTE  (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CSX       (CSX),
        .SCK       (SCK),
        .SDI       (SDI),
        .SDO       (SDO),
        .SDO_OE    (SDO_OE),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .selected  (selected)
`ifdef SPI_TARGET_OVERRUN_EN
        ,
        .rx_overrun(rx_overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic csx_low();
        CSX = 1'b0;
        wait_neg(HALF);
    endtask

    task automatic csx_high();
        CSX = 1'b1;
        wait_neg(HALF);
    endtask

    // Clocks out nbits of mosi (MSB first) and captures SDO on each rise.
    // ack_last pulses rx_ack in the clk where the last bit completes.
    task automatic xfer(input logic [7:0] mosi, input int nbits,
                        input logic ack_last, output logic [7:0] miso);
        miso = '0;
        for (int k = 0; k < nbits; k++) begin
            SDI = mosi[7-k];
            wait_neg(HALF);
            SCK = 1'b1;
            miso[7-k] = SDO;
            if (ack_last && k == nbits - 1) begin
                wait_neg(SYNC + 1);
                pulse_ack();
                wait_neg(HALF - SYNC - 2);
            end else begin
                wait_neg(HALF);
            end
            SCK = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] mosi, input logic ack_last,
                         output logic [7:0] miso);
        csx_low();
        xfer(mosi, 8, ack_last, miso);
        csx_high();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; CSX = 1'b1; SCK = 1'b0; SDI = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(4);
        checks++; if (SDO !== 1'b0) begin fails++; $display("FAIL reset_sdo: got %b expected 0", SDO); end
        checks++; if (SDO_OE !== 1'b0) begin fails++; $display("FAIL reset_sdo_oe: got %b expected 0", SDO_OE); end
        checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (selected !== 1'b0) begin fails++; $display("FAIL reset_selected: got %b expected 0", selected); end
`ifdef SPI_TARGET_OVERRUN_EN
        checks++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_rx_overrun: got %b expected 0", rx_overrun); end
`endif
    endtask

    task automatic test_single_frame();
        logic [7:0] miso;
        write_tx(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL single_tx_full: got %b expected 0", tx_ready); end
        csx_low();
        checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL single_tx_ready_at_csx: got %b expected 1", tx_ready); end
        checks++; if (SDO_OE !== 1'b1) begin fails++; $display("FAIL single_sdo_oe: got %b expected 1", SDO_OE); end
        checks++; if (selected !== 1'b1) begin fails++; $display("FAIL single_selected: got %b expected 1", selected); end
        xfer(8'h3C, 8, 1'b0, miso);
        checks++; if (miso !== 8'hA5) begin fails++; $display("FAIL single_miso: got %h expected a5", miso); end
        checks++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_data: got %h expected 3c", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL single_rx_valid: got %b expected 1", rx_valid); end
        csx_high();
        checks++; if (SDO_OE !== 1'b0) begin fails++; $display("FAIL single_sdo_oe_idle: got %b expected 0", SDO_OE); end
        pulse_ack();
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL single_ack: got %b expected 0", rx_valid); end
    endtask

    task automatic test_empty_tx();
        logic [7:0] miso;
        frame(8'h81, 1'b0, miso);
        checks++; if (miso !== 8'h00) begin fails++; $display("FAIL empty_miso: got %h expected 00", miso); end
        checks++; if (rx_data !== 8'h81) begin fails++; $display("FAIL empty_rx_data: got %h expected 81", rx_data); end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1;
        logic [7:0] m2;
        write_tx(8'h12);
        csx_low();
        checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_byte1: got %b expected 1", tx_ready); end
        write_tx(8'h34);
        xfer(8'hF0, 8, 1'b0, m1);
        checks++; if (rx_data !== 8'hF0) begin fails++; $display("FAIL b2b_rx1: got %h expected f0", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_rx1_valid: got %b expected 1", rx_valid); end
        pulse_ack();
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL b2b_rx1_ack: got %b expected 0", rx_valid); end
        xfer(8'h0F, 8, 1'b0, m2);
        checks++; if (m1 !== 8'h12) begin fails++; $display("FAIL b2b_miso1: got %h expected 12", m1); end
        checks++; if (m2 !== 8'h34) begin fails++; $display("FAIL b2b_miso2: got %h expected 34", m2); end
        checks++; if (rx_data !== 8'h0F) begin fails++; $display("FAIL b2b_rx2: got %h expected 0f", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_rx2_valid: got %b expected 1", rx_valid); end
        csx_high();
        pulse_ack();
    endtask

    task automatic test_abort();
        logic [7:0] miso;
        csx_low();
        xfer(8'hFF, 5, 1'b0, miso);
        CSX = 1'b1;
        wait_neg(SYNC + 1);
        checks++; if (SDO_OE !== 1'b0) begin fails++; $display("FAIL abort_sdo_oe: got %b expected 0", SDO_OE); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL abort_rx_valid: got %b expected 0", rx_valid); end
        wait_neg(HALF);
        frame(8'h55, 1'b0, miso);
        checks++; if (rx_data !== 8'h55) begin fails++; $display("FAIL abort_next_rx: got %h expected 55", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL abort_next_valid: got %b expected 1", rx_valid); end
        pulse_ack();
    endtask

    task automatic test_overrun();
        logic [7:0] miso;
        frame(8'h11, 1'b0, miso);
        frame(8'h22, 1'b0, miso);
        checks++; if (rx_data !== 8'h22) begin fails++; $display("FAIL ovr_rx_data: got %h expected 22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_rx_valid: got %b expected 1", rx_valid); end
`ifdef SPI_TARGET_OVERRUN_EN
        checks++; if (rx_overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag_set: got %b expected 1", rx_overrun); end
`endif
        pulse_ack();
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_ack_valid: got %b expected 0", rx_valid); end
`ifdef SPI_TARGET_OVERRUN_EN
        checks++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL ovr_flag_clear: got %b expected 0", rx_overrun); end
`endif
        // Ack collides with the completion of 8'h44: completion wins.
        frame(8'h33, 1'b0, miso);
        frame(8'h44, 1'b1, miso);
        checks++; if (rx_valid !== 1'b1) begin fails++; $display("FAIL ack_collide_valid: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h44) begin fails++; $display("FAIL ack_collide_data: got %h expected 44", rx_data); end
`ifdef SPI_TARGET_OVERRUN_EN
        checks++; if (rx_overrun !== 1'b0) begin fails++; $display("FAIL ack_collide_ovr: got %b expected 0", rx_overrun); end
`endif
        pulse_ack();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] miso;
        frame(8'h5A, 1'b0, miso);
        csx_low();
        write_tx(8'h77);
        xfer(8'hC3, 4, 1'b0, miso);
        rst_n = 1'b0;
        #1;
        checks++; if (SDO !== 1'b0) begin fails++; $display("FAIL rst_mid_sdo: got %b expected 0", SDO); end
        checks++; if (SDO_OE !== 1'b0) begin fails++; $display("FAIL rst_mid_sdo_oe: got %b expected 0", SDO_OE); end
        checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_mid_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (selected !== 1'b0) begin fails++; $display("FAIL rst_mid_selected: got %b expected 0", selected); end
        wait_neg(3);
        rst_n = 1'b1;
        // CSX is still low: this byte must be ignored.
        xfer(8'hC3, 8, 1'b0, miso);
        checks++; if (SDO_OE !== 1'b0) begin fails++; $display("FAIL rst_rel_sdo_oe: got %b expected 0", SDO_OE); end
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rel_rx_valid: got %b expected 0", rx_valid); end
        csx_high();
        frame(8'h96, 1'b0, miso);
        checks++; if (rx_data !== 8'h96) begin fails++; $display("FAIL rst_rel_next_rx: got %h expected 96", rx_data); end
        checks++; if (miso !== 8'h00) begin fails++; $display("FAIL rst_rel_next_miso: got %h expected 00", miso); end
        pulse_ack();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_single_frame();
        test_empty_tx();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
